// File: rtl/vga_console_pkg.sv
// Shared constants and tag types for the VGA text console fetch path.
package vga_console_pkg;

    localparam int unsigned COLS       = 32;
    localparam int unsigned ROWS       = 16;
    localparam int unsigned ADDR_W     = 9;
    localparam int unsigned H_LAST     = 41;
    localparam int unsigned FETCH_SLOT = 28;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned XHI_W  = 6;
    localparam int unsigned XLO_W  = 5;
    localparam int unsigned YHI_W  = 5;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_CPU  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   is_read;
    } fetch_tag_t;

endpackage

// File: rtl/vga_text_fetch_arbiter_if.sv
// CPU handshake and character-RAM bus bundled for the fetch arbiter.
interface vga_text_fetch_arbiter_if;
    import vga_console_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // master: the arbiter; slave: the CPU and the RAM it fronts
    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output cpu_ready, cpu_rdata, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  cpu_ready, cpu_rdata, ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/vga_fetch_tag_pipe.sv
// Two-stage owner tag pipe: routes RAM read data to the CPU or the display
// prefetch buffer and generates the CPU completion pulse.
module vga_fetch_tag_pipe
    import vga_console_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  fetch_tag_t        tag_i,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              cpu_ready_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic [DATA_W-1:0] prefetch_o
);

    fetch_tag_t        stage0_q, stage1_q;
    logic              cpu_ready_d, cpu_ready_q;
    logic [DATA_W-1:0] cpu_rdata_d, cpu_rdata_q;
    logic [DATA_W-1:0] prefetch_d, prefetch_q;

    // stage0 = access on the RAM bus this cycle, stage1 = its data returning
    always_comb begin
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        prefetch_d  = prefetch_q;
        if (stage0_q.valid && stage0_q.owner == OWN_CPU && !stage0_q.is_read) begin
            cpu_ready_d = 1'b1;
        end
        if (stage1_q.valid && stage1_q.owner == OWN_CPU && stage1_q.is_read) begin
            cpu_ready_d = 1'b1;
            cpu_rdata_d = ram_rdata_i;
        end
        if (stage1_q.valid && stage1_q.owner == OWN_DISP) begin
            prefetch_d = ram_rdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage0_q    <= '0;
            stage1_q    <= '0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            prefetch_q  <= '0;
        end else begin
            stage0_q    <= tag_i;
            stage1_q    <= stage0_q;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            prefetch_q  <= prefetch_d;
        end
    end

    assign cpu_ready_o = cpu_ready_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign prefetch_o  = prefetch_q;

endmodule

// File: rtl/vga_text_fetch_arbiter.sv
// Shares the character RAM between beam-scheduled display fetches (priority)
// and CPU accesses, and presents the current cell's character code.
module vga_text_fetch_arbiter
    import vga_console_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [XHI_W-1:0]     x_hi,
    input  logic [XLO_W-1:0]     x_lo,
    input  logic [YHI_W-1:0]     y_hi,
    vga_text_fetch_arbiter_if.master bus,
    output logic [DATA_W-1:0]    char_code
);

    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned ROW_W = $clog2(ROWS);

    logic              row_vis_c, col_fetch_c, wrap_col_c, blank_col_c;
    logic              disp_hit_c, cpu_grant_c;
    logic [COL_W-1:0]  fetch_col_c;
    logic [ADDR_W-1:0] disp_addr_c;
    fetch_tag_t        tag_c;

    logic              ram_en_d, ram_en_q;
    logic              ram_we_d, ram_we_q;
    logic [ADDR_W-1:0] ram_addr_d, ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_d, ram_wdata_q;
    logic              busy_d, busy_q;
    logic [DATA_W-1:0] char_code_d, char_code_q;

    logic              pipe_cpu_ready;
    logic [DATA_W-1:0] pipe_cpu_rdata;
    logic [DATA_W-1:0] pipe_prefetch;

    // Beam decode: column-0 fetch happens at the wrap column of the previous line
    assign row_vis_c   = y_hi < YHI_W'(ROWS);
    assign col_fetch_c = x_hi < XHI_W'(COLS - 1);
    assign wrap_col_c  = x_hi == XHI_W'(H_LAST);
    assign blank_col_c = x_hi == XHI_W'(COLS - 1);
    assign fetch_col_c = wrap_col_c ? '0 : x_hi[COL_W-1:0] + COL_W'(1);
    assign disp_addr_c = {y_hi[ROW_W-1:0], fetch_col_c};
    assign disp_hit_c  = (x_lo == XLO_W'(FETCH_SLOT)) && row_vis_c
                         && (col_fetch_c || wrap_col_c);
    // The ready cycle frees the CPU slot so a held request re-issues at once
    assign cpu_grant_c = !disp_hit_c && bus.cpu_req && (!busy_q || pipe_cpu_ready);

    always_comb begin
        tag_c       = '0;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        busy_d      = busy_q;
        char_code_d = char_code_q;

        if (pipe_cpu_ready) begin
            busy_d = 1'b0;
        end

        if (disp_hit_c) begin
            ram_en_d   = 1'b1;
            ram_addr_d = disp_addr_c;
            tag_c      = '{valid: 1'b1, owner: OWN_DISP, is_read: 1'b1};
        end else if (cpu_grant_c) begin
            ram_en_d    = 1'b1;
            ram_we_d    = bus.cpu_we;
            ram_addr_d  = bus.cpu_addr;
            ram_wdata_d = bus.cpu_wdata;
            busy_d      = 1'b1;
            tag_c       = '{valid: 1'b1, owner: OWN_CPU, is_read: !bus.cpu_we};
        end

        if (x_lo == XLO_W'(31)) begin
            if (col_fetch_c || wrap_col_c) begin
                char_code_d = row_vis_c ? pipe_prefetch : '0;
            end else if (blank_col_c) begin
                char_code_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            busy_q      <= 1'b0;
            char_code_q <= '0;
        end else begin
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            busy_q      <= busy_d;
            char_code_q <= char_code_d;
        end
    end

    vga_fetch_tag_pipe u_tag_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .tag_i       (tag_c),
        .ram_rdata_i (bus.ram_rdata),
        .cpu_ready_o (pipe_cpu_ready),
        .cpu_rdata_o (pipe_cpu_rdata),
        .prefetch_o  (pipe_prefetch)
    );

    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.cpu_ready = pipe_cpu_ready;
    assign bus.cpu_rdata = pipe_cpu_rdata;
    assign char_code     = char_code_q;

endmodule

// File: tb/tb_vga_text_fetch_arbiter.sv
// Scoreboard bench for the VGA text fetch arbiter with a behavioural char RAM.
module tb_vga_text_fetch_arbiter;
    import vga_console_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] x_hi = '0;
    logic [4:0] x_lo = '0;
    logic [4:0] y_hi = 5'd16;
    logic [7:0] char_code;

    vga_text_fetch_arbiter_if bus();

    vga_text_fetch_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_hi      (x_hi),
        .x_lo      (x_lo),
        .y_hi      (y_hi),
        .bus       (bus),
        .char_code (char_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_read;
        logic [8:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } cpu_exp_t;

    cpu_exp_t   exp_q[$];
    cpu_exp_t   mon_e;
    logic [7:0] ram    [512];
    logic [7:0] shadow [512];
    logic       preload = 1'b0;
    logic       bd_we = 1'b0;
    logic [8:0] bd_addr = '0;
    logic [7:0] bd_data = '0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         ready_cnt = 0;
    int         en_cnt = 0;
    logic       count_en = 1'b0;

    function automatic logic [7:0] pat(input int i);
        return 8'(i) | 8'h80;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Behavioural RAM: samples at the edge ending the ram_en cycle
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) ram[i] <= pat(i);
        end else if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end
        if (bus.ram_en) begin
            if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata <= ram[bus.ram_addr];
        end
    end

    // CPU completion monitor: pops the scoreboard
    always @(negedge clk) begin
        if (rst_n && count_en && bus.ram_en) en_cnt++;
        if (rst_n && bus.cpu_ready) begin
            ready_cnt++;
            if (exp_q.size() == 0) begin
                chk("spurious_ready", 32'(bus.cpu_ready), 32'(0));
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_read) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(mon_e.rdata));
                else               chk("cpu_wr_mem", 32'(ram[mon_e.addr]), 32'(mon_e.wdata));
            end
        end
    end

    task automatic beam_step();
        if (x_lo == 5'd31) begin
            x_lo = '0;
            x_hi = (x_hi == 6'd41) ? 6'd0 : x_hi + 6'd1;
            if (x_hi == 6'd37) y_hi = (y_hi == 5'd19) ? 5'd0 : y_hi + 5'd1;
        end else begin
            x_lo = x_lo + 5'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        beam_step();
    endtask

    task automatic set_beam(input int y, input int xh, input int xl);
        y_hi = 5'(y);
        x_hi = 6'(xh);
        x_lo = 5'(xl);
    endtask

    task automatic bd_write(input int addr, input int data);
        bd_addr = 9'(addr);
        bd_data = 8'(data);
        bd_we   = 1'b1;
        tick();
        bd_we   = 1'b0;
        shadow[addr] = 8'(data);
    endtask

    task automatic cpu_issue(input logic we, input int addr, input int wdata);
        cpu_exp_t e;
        e.is_read = !we;
        e.addr    = 9'(addr);
        e.wdata   = 8'(wdata);
        e.rdata   = shadow[addr];
        exp_q.push_back(e);
        if (we) shadow[addr] = 8'(wdata);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = 9'(addr);
        bus.cpu_wdata = 8'(wdata);
    endtask

    task automatic cpu_wait(input int max, output int lat);
        lat = 0;
        while (lat < max) begin
            tick();
            lat++;
            if (bus.cpu_ready) break;
        end
        if (!bus.cpu_ready) begin
            chk("cpu_timeout", 32'(0), 32'(1));
            exp_q.delete();
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic run_to(input int xh, input int xl);
        int n = 0;
        while (!(x_hi == 6'(xh) && x_lo == 5'(xl)) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) chk("run_to_timeout", 32'(n), 32'(0));
        tick();
    endtask

    initial begin
        int lat;
        int n_acc;
        int start;
        logic we;
        int addr;

        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        for (int i = 0; i < 512; i++) shadow[i] = pat(i);
        preload = 1'b1;
        tick();
        preload = 1'b0;
        tick();
        chk("rst_ram_en",    32'(bus.ram_en),    32'(0));
        chk("rst_ram_we",    32'(bus.ram_we),    32'(0));
        chk("rst_ram_addr",  32'(bus.ram_addr),  32'(0));
        chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'(0));
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'(0));
        chk("rst_char_code", 32'(char_code),     32'(0));
        rst_n = 1'b1;
        tick();

        // Display fetch of row 3 col 5
        bd_write(12'h065, 8'h41);
        set_beam(3, 4, 27);
        tick();
        tick();
        chk("t1_ram_en",   32'(bus.ram_en),   32'(1));
        chk("t1_ram_we",   32'(bus.ram_we),   32'(0));
        chk("t1_ram_addr", 32'(bus.ram_addr), 32'h065);
        tick(); tick(); tick();
        chk("t1_char", 32'(char_code), 32'h41);

        // Wrap-column fetch of column 0, then blanking entry
        bd_write(12'h0E0, 8'h5A);
        set_beam(7, 41, 27);
        tick();
        tick();
        chk("t2_ram_addr", 32'(bus.ram_addr), 32'h0E0);
        tick(); tick(); tick();
        chk("t2_char", 32'(char_code), 32'h5A);
        set_beam(7, 31, 31);
        tick();
        chk("t2_blank_char", 32'(char_code), 32'(0));

        // CPU write then display of the same cell
        set_beam(15, 30, 10);
        cpu_issue(1'b1, 9'h1FF, 8'h33);
        tick();
        chk("t3_ram_en",    32'(bus.ram_en),    32'(1));
        chk("t3_ram_we",    32'(bus.ram_we),    32'(1));
        chk("t3_ram_addr",  32'(bus.ram_addr),  32'h1FF);
        chk("t3_ram_wdata", 32'(bus.ram_wdata), 32'h33);
        cpu_wait(8, lat);
        chk("t3_wr_lat", 32'(lat), 32'(1));
        run_to(30, 31);
        chk("t3_char", 32'(char_code), 32'h33);

        // CPU read colliding with the display slot
        bd_write(12'h04A, 8'h11);
        bd_write(12'h010, 8'h7E);
        set_beam(2, 9, 27);
        tick();
        cpu_issue(1'b0, 9'h010, 0);
        tick();
        chk("t4_disp_addr", 32'(bus.ram_addr), 32'h04A);
        chk("t4_disp_we",   32'(bus.ram_we),   32'(0));
        tick();
        chk("t4_cpu_en",    32'(bus.ram_en),   32'(1));
        chk("t4_cpu_addr",  32'(bus.ram_addr), 32'h010);
        cpu_wait(8, lat);
        chk("t4_rd_lat", 32'(lat), 32'(2));
        chk("t4_char",   32'(char_code), 32'h11);

        // CPU read directly ahead of the display fetch
        set_beam(4, 19, 27);
        cpu_issue(1'b0, 9'h123, 0);
        tick();
        chk("t5_cpu_addr",  32'(bus.ram_addr), 32'h123);
        tick();
        chk("t5_disp_en",   32'(bus.ram_en),   32'(1));
        chk("t5_disp_addr", 32'(bus.ram_addr), 32'h094);
        cpu_wait(8, lat);
        chk("t5_rd_lat", 32'(lat), 32'(1));
        run_to(19, 31);
        chk("t5_char", 32'(char_code), 32'(shadow[9'h094]));

        // Random CPU traffic during active display
        set_beam(0, 0, 0);
        for (int k = 0; k < 150; k++) begin
            we   = 1'($urandom_range(0, 1));
            addr = int'($urandom_range(0, 511));
            cpu_issue(we, addr, int'($urandom_range(0, 255)));
            cpu_wait(10, lat);
            chk("act_lat", 32'(lat <= (we ? 3 : 4)), 32'(1));
        end

        // Vertical blanking: only CPU traffic for a whole line
        set_beam(16, 0, 0);
        en_cnt   = 0;
        n_acc    = 0;
        start    = cyc;
        count_en = 1'b1;
        while (cyc - start < 1344) begin
            we   = 1'($urandom_range(0, 1));
            addr = int'($urandom_range(0, 511));
            cpu_issue(we, addr, int'($urandom_range(0, 255)));
            cpu_wait(10, lat);
            n_acc++;
            chk("blank_lat", 32'(lat), 32'(we ? 2 : 3));
        end
        tick();
        count_en = 1'b0;
        chk("blank_ram_en_cnt", 32'(en_cnt), 32'(n_acc));
        chk("blank_char", 32'(char_code), 32'(0));

        // Reset while a CPU read is in flight
        set_beam(16, 0, 0);
        cpu_issue(1'b0, 9'h094, 0);
        tick();
        chk("t7_granted", 32'(bus.ram_en), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("t7_ram_en",    32'(bus.ram_en),    32'(0));
        chk("t7_ram_addr",  32'(bus.ram_addr),  32'(0));
        chk("t7_cpu_ready", 32'(bus.cpu_ready), 32'(0));
        chk("t7_cpu_rdata", 32'(bus.cpu_rdata), 32'(0));
        chk("t7_char",      32'(char_code),     32'(0));
        exp_q.delete();
        bus.cpu_req = 1'b0;
        start = ready_cnt;
        tick(); tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        chk("t7_no_ready", 32'(ready_cnt - start), 32'(0));
        chk("t7_idle_en",  32'(bus.ram_en),        32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
